twi_reg_sched: RTL and testbench

TWI_REG_SCHED -- requirements
Module: twi_reg_sched

---
 rtl/twi_pkg.sv | 20 ++
 rtl/twi_reg_arb.sv | 41 ++++
 rtl/twi_reg_sched.sv | 135 +++++++++++++
 tb/tb_twi_reg_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twi_pkg.sv
// Shared types and default sizing for the TWI register scheduler.
package twi_pkg;

  localparam int unsigned ADDR_W_DEF       = 4;
  localparam int unsigned INT_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2
  } twi_state_e;

  // Kind of TWI access held in the one-entry pending slot
  typedef enum logic [1:0] {
    OP_PTR = 2'd0,
    OP_WR  = 2'd1,
    OP_RD  = 2'd2
  } twi_op_e;

endpackage

// File: rtl/twi_reg_arb.sv
// Per-cycle arbiter between the pending TWI access and the internal requester,
// with a starvation counter that forces an internal grant after INT_MAX_WAIT losses.
module twi_reg_arb
  import twi_pkg::*;
#(
  parameter int unsigned INT_MAX_WAIT = INT_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic twi_pend,
  input  logic int_req,
  output logic twi_sel,
  output logic int_gnt
);

  localparam int unsigned SW = (INT_MAX_WAIT < 1) ? 1 : $clog2(INT_MAX_WAIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          force_int;

  always_comb begin
    force_int = (starve_q == SW'(INT_MAX_WAIT));
    int_gnt   = int_req && (!twi_pend || force_int);
    twi_sel   = twi_pend && !int_gnt;
    starve_d  = starve_q;
    if (int_gnt) begin
      starve_d = '0;
    end else if (int_req) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/twi_reg_sched.sv
// TWI-slave register file shared with an internal requester (one access per cycle).
// Macro TWI_REG_SCHED_AUTOINC_EN enables pointer auto-increment after each data access.
module twi_reg_sched
  import twi_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned INT_MAX_WAIT = INT_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              twi_start,
  input  logic              twi_stop,
  input  logic              twi_wr_valid,
  input  logic [7:0]        twi_wr_data,
  input  logic              twi_rd_req,
  output logic [7:0]        twi_rd_data,
  output logic              twi_ack,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [7:0]        int_wdata,
  output logic              int_gnt,
  output logic [7:0]        int_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  twi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  twi_op_e           pend_op_q, pend_op_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              ack_q, ack_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        irdata_q, irdata_d;
  logic [7:0]        file_q [DEPTH];
  logic [7:0]        file_d [DEPTH];
  logic              twi_sel;
  logic              slot_free;

  twi_reg_arb #(
    .INT_MAX_WAIT(INT_MAX_WAIT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .twi_pend(pend_q),
    .int_req (int_req),
    .twi_sel (twi_sel),
    .int_gnt (int_gnt)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q;
    pend_op_d   = pend_op_q;
    pend_data_d = pend_data_q;
    ack_d       = 1'b0;
    rd_data_d   = rd_data_q;
    irdata_d    = irdata_q;
    file_d      = file_q;

    if (twi_sel) begin
      pend_d = 1'b0;
      ack_d  = 1'b1;
      case (pend_op_q)
        OP_PTR: ptr_d = pend_data_q[ADDR_W-1:0];
        OP_WR: begin
          file_d[ptr_q] = pend_data_q;
`ifdef TWI_REG_SCHED_AUTOINC_EN
          ptr_d = ptr_q + 1'b1;
`endif
        end
        default: begin
          rd_data_d = file_q[ptr_q];
`ifdef TWI_REG_SCHED_AUTOINC_EN
          ptr_d = ptr_q + 1'b1;
`endif
        end
      endcase
    end else if (int_gnt) begin
      if (int_we) begin
        file_d[int_addr] = int_wdata;
      end else begin
        irdata_d = file_q[int_addr];
      end
    end

    // The slot may be refilled in the same cycle it is being served
    slot_free = !pend_q || twi_sel;
    if (slot_free && (state_q != ST_IDLE) && (twi_wr_valid || twi_rd_req)) begin
      pend_d      = 1'b1;
      pend_data_d = twi_wr_data;
      if (twi_wr_valid) begin
        pend_op_d = (state_q == ST_PTR) ? OP_PTR : OP_WR;
      end else begin
        pend_op_d = OP_RD;
      end
      state_d = ST_DATA;
    end

    // An already-accepted access still completes across START/STOP
    if (twi_start) state_d = ST_PTR;
    if (twi_stop)  state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      pend_op_q   <= OP_PTR;
      pend_data_q <= '0;
      ack_q       <= 1'b0;
      rd_data_q   <= '0;
      irdata_q    <= '0;
      file_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_op_q   <= pend_op_d;
      pend_data_q <= pend_data_d;
      ack_q       <= ack_d;
      rd_data_q   <= rd_data_d;
      irdata_q    <= irdata_d;
      file_q      <= file_d;
    end
  end

  assign twi_ack     = ack_q;
  assign twi_rd_data = rd_data_q;
  assign int_rdata   = irdata_q;

endmodule

// File: tb/tb_twi_reg_sched.sv
// Directed self-checking bench for twi_reg_sched; expectations follow the
// TWI_REG_SCHED_AUTOINC_EN setting of the build.
module tb_twi_reg_sched;
  import twi_pkg::*;

`ifdef TWI_REG_SCHED_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       twi_start, twi_stop, twi_wr_valid, twi_rd_req;
  logic [7:0] twi_wr_data;
  logic [7:0] twi_rd_data;
  logic       twi_ack;
  logic       int_req, int_we;
  logic [3:0] int_addr;
  logic [7:0] int_wdata;
  logic       int_gnt;
  logic [7:0] int_rdata;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  twi_reg_sched #(
    .ADDR_W      (4),
    .INT_MAX_WAIT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .twi_start   (twi_start),
    .twi_stop    (twi_stop),
    .twi_wr_valid(twi_wr_valid),
    .twi_wr_data (twi_wr_data),
    .twi_rd_req  (twi_rd_req),
    .twi_rd_data (twi_rd_data),
    .twi_ack     (twi_ack),
    .int_req     (int_req),
    .int_we      (int_we),
    .int_addr    (int_addr),
    .int_wdata   (int_wdata),
    .int_gnt     (int_gnt),
    .int_rdata   (int_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    twi_start = 1'b1;
    tick();
    twi_start = 1'b0;
  endtask

  task automatic pulse_stop();
    twi_stop = 1'b1;
    tick();
    twi_stop = 1'b0;
  endtask

  // lat = cycles from the pulse cycle to the ack cycle, 0 if no ack within budget
  task automatic twi_wr(input logic [7:0] d, output int lat);
    twi_wr_valid = 1'b1;
    twi_wr_data  = d;
    tick();
    twi_wr_valid = 1'b0;
    lat = 0;
    for (int i = 2; i <= 11; i++) begin
      tick();
      if (twi_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic twi_rd(output logic [7:0] d, output int lat);
    twi_rd_req = 1'b1;
    tick();
    twi_rd_req = 1'b0;
    lat = 0;
    d   = 8'hxx;
    for (int i = 2; i <= 11; i++) begin
      tick();
      if (twi_ack) begin
        lat = i;
        d   = twi_rd_data;
        break;
      end
    end
  endtask

  // wcyc = cycle (1-based) in which int_gnt was seen, 0 if never
  task automatic int_access(input logic we, input logic [3:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int wcyc);
    int_req   = 1'b1;
    int_we    = we;
    int_addr  = a;
    int_wdata = wd;
    wcyc      = 0;
    rd        = 8'hxx;
    for (int i = 1; i <= 10; i++) begin
      #1;
      if (int_gnt) begin
        wcyc = i;
        @(posedge clk);
        #1;
        rd = int_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    int_req = 1'b0;
  endtask

  function automatic int nonzero_entries();
    int n = 0;
    for (int i = 0; i < 16; i++) if (dut.file_q[i] !== 8'h00) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    twi_start = 0; twi_stop = 0; twi_wr_valid = 0; twi_rd_req = 0; twi_wr_data = '0;
    int_req = 0; int_we = 0; int_addr = '0; int_wdata = '0;
    tick(); tick();
    n_total++; if (twi_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", twi_ack); else n_pass++;
    n_total++; if (int_gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", int_gnt); else n_pass++;
    n_total++; if (twi_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", twi_rd_data); else n_pass++;
    n_total++; if (int_rdata !== 8'h00) $display("FAIL reset_int_rdata: got %h want 00", int_rdata); else n_pass++;
    n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    n_total++; if (nonzero_entries() !== 0) $display("FAIL reset_file: got %0d nonzero want 0", nonzero_entries()); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    int acks = 0;
    twi_wr_valid = 1'b1; twi_wr_data = 8'h33;
    tick();
    twi_wr_valid = 1'b0;
    twi_rd_req = 1'b1;
    tick();
    twi_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (twi_ack) acks++; end
    n_total++; if (acks !== 0) $display("FAIL idle_no_ack: got %0d acks want 0", acks); else n_pass++;
    n_total++; if (dut.ptr_q !== 4'h0) $display("FAIL idle_ptr: got %h want 0", dut.ptr_q); else n_pass++;
  endtask

  task automatic test_write_seq();
    int l0, l1, l2, acks;
    pulse_start();
    twi_wr(8'h03, l0);
    twi_wr(8'hAA, l1);
    twi_wr(8'h55, l2);
    pulse_stop();
    tick();
    acks = (l0 != 0 ? 1 : 0) + (l1 != 0 ? 1 : 0) + (l2 != 0 ? 1 : 0);
    n_total++; if (l0 !== 2) $display("FAIL wr_latency: got %0d want 2", l0); else n_pass++;
    n_total++; if (acks !== 3) $display("FAIL wr_acks: got %0d want 3", acks); else n_pass++;
    n_total++; if (dut.file_q[3] !== (AUTOINC ? 8'hAA : 8'h55)) $display("FAIL wr_file3: got %h want %h", dut.file_q[3], AUTOINC ? 8'hAA : 8'h55); else n_pass++;
    n_total++; if (dut.file_q[4] !== (AUTOINC ? 8'h55 : 8'h00)) $display("FAIL wr_file4: got %h want %h", dut.file_q[4], AUTOINC ? 8'h55 : 8'h00); else n_pass++;
    n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL wr_stop_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
  endtask

  task automatic test_read_wrap();
    logic [7:0] d0, d1, dummy;
    int l, w;
    int_access(1'b1, 4'hF, 8'h11, dummy, w);
    int_access(1'b1, 4'h0, 8'h22, dummy, w);
    pulse_start();
    twi_wr(8'h0F, l);
    twi_rd(d0, l);
    twi_rd(d1, l);
    pulse_stop();
    n_total++; if (d0 !== 8'h11) $display("FAIL rd_first: got %h want 11", d0); else n_pass++;
    n_total++; if (d1 !== (AUTOINC ? 8'h22 : 8'h11)) $display("FAIL rd_wrap: got %h want %h", d1, AUTOINC ? 8'h22 : 8'h11); else n_pass++;
  endtask

  task automatic test_int_rw();
    logic [7:0] r, d;
    int w, l;
    int_access(1'b1, 4'h2, 8'h7E, r, w);
    n_total++; if (w !== 1) $display("FAIL int_gnt_wait: got %0d want 1", w); else n_pass++;
    int_access(1'b0, 4'h2, 8'h00, r, w);
    n_total++; if (r !== 8'h7E) $display("FAIL int_rdata: got %h want 7e", r); else n_pass++;
    pulse_start();
    twi_wr(8'h02, l);
    twi_rd(d, l);
    pulse_stop();
    n_total++; if (d !== 8'h7E) $display("FAIL int_then_twi_rd: got %h want 7e", d); else n_pass++;
  endtask

  task automatic test_ptr_noinc();
    int l;
    pulse_start();
    twi_wr(8'h05, l);
    twi_wr(8'h01, l);
    twi_wr(8'h02, l);
    pulse_stop();
    tick();
    n_total++; if (dut.file_q[5] !== (AUTOINC ? 8'h01 : 8'h02)) $display("FAIL noinc_file5: got %h want %h", dut.file_q[5], AUTOINC ? 8'h01 : 8'h02); else n_pass++;
    n_total++; if (dut.file_q[6] !== (AUTOINC ? 8'h02 : 8'h00)) $display("FAIL noinc_file6: got %h want %h", dut.file_q[6], AUTOINC ? 8'h02 : 8'h00); else n_pass++;
  endtask

  task automatic test_stop_pending();
    int l;
    pulse_start();
    twi_wr(8'h08, l);
    twi_wr_valid = 1'b1; twi_wr_data = 8'h5A;
    tick();
    twi_wr_valid = 1'b0;
    twi_stop = 1'b1;
    tick();
    twi_stop = 1'b0;
    n_total++; if (twi_ack !== 1'b1) $display("FAIL stop_pend_ack: got %b want 1", twi_ack); else n_pass++;
    n_total++; if (dut.file_q[8] !== 8'h5A) $display("FAIL stop_pend_file: got %h want 5a", dut.file_q[8]); else n_pass++;
    n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL stop_pend_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    tick();
  endtask

  task automatic test_starve();
    int l, gcyc;
    pulse_start();
    twi_wr(8'h00, l);
    twi_rd_req = 1'b1;
    tick();
    int_req = 1'b1; int_we = 1'b1; int_addr = 4'h9; int_wdata = 8'h3C;
    gcyc = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (int_gnt) begin
        gcyc = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    int_req = 1'b0;
    twi_rd_req = 1'b0;
    tick(); tick();
    pulse_stop();
    tick();
    n_total++; if (gcyc !== 5) $display("FAIL starve_gnt_cycle: got %0d want 5", gcyc); else n_pass++;
    n_total++; if (dut.file_q[9] !== 8'h3C) $display("FAIL starve_write: got %h want 3c", dut.file_q[9]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int l, acks = 0;
    pulse_start();
    twi_wr(8'h05, l);
    twi_wr_valid = 1'b1; twi_wr_data = 8'h99;
    tick();
    twi_wr_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (twi_ack) acks++; end
    n_total++; if (acks !== 0) $display("FAIL rstmid_no_ack: got %0d want 0", acks); else n_pass++;
    n_total++; if (nonzero_entries() !== 0) $display("FAIL rstmid_file: got %0d nonzero want 0", nonzero_entries()); else n_pass++;
    n_total++; if (dut.state_q !== ST_IDLE) $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    n_total++; if (dut.ptr_q !== 4'h0) $display("FAIL rstmid_ptr: got %h want 0", dut.ptr_q); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_write_seq();
    test_read_wrap();
    test_int_rw();
    test_ptr_noinc();
    test_stop_pending();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
